// File: rtl/my_int_ctrl_if.sv
// Interrupt controller bus: external requests, PC/trap handshake and debug taps.
// Handshake: int_cause is a registered trap request that is nonzero for exactly
// one clk cycle per accepted trap (the PC samples it on the next posedge);
// mret is a one-cycle strobe from the trap unit that is honoured only when a
// handler is active (or while mie is still clear after reset); hold=1 defers
// a new trap without losing the pending request.
interface my_int_ctrl_if;
  logic [2:0] irq_in;
  logic       hold;
  logic       mret;
  logic [1:0] int_cause;
  logic       in_handler;
  logic [2:0] pending;
  logic [1:0] state;   // FSM state tap: 0=IDLE, 1=TRAP, 2=HANDLER

  // master: the interrupt controller itself
  modport master (
    input  irq_in, hold, mret,
    output int_cause, in_handler, pending, state
  );

  // slave: the PC/trap unit and interrupt sources
  modport slave (
    output irq_in, hold, mret,
    input  int_cause, in_handler, pending, state
  );
endinterface

// File: rtl/my_int_ctrl.sv
// Three-source fixed-priority interrupt controller for a single-return-address PC.
// Optional macro INT_SYNC_EN: adds a 2-flop synchronizer on irq_in (2 cycles
// extra latency); when undefined irq_in is assumed synchronous to clk.
module my_int_ctrl #(
  parameter int EDGE_MODE = 1,
  parameter bit RESET_MIE = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  my_int_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t     state_q, state_n;
  logic [1:0] cause_q, cause_n;
  logic       inh_q, inh_n;
  logic       mie_q, mie_n;
  logic [2:0] pend_q, pend_n;
  logic [2:0] irq_prev;
  logic [2:0] irq_s;
  logic [2:0] rise;
  logic [2:0] pend_vec;
  logic [2:0] clr;
  logic [1:0] hi_cause;
  logic [2:0] hi_onehot;

`ifdef INT_SYNC_EN
  logic [2:0] sync1, sync2;

  // Two-flop synchronizer for asynchronous interrupt sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= bus.irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = bus.irq_in;
`endif

  assign rise     = irq_s & ~irq_prev;
  // Level mode reports the live (possibly synchronized) input as pending
  assign pend_vec = (EDGE_MODE != 0) ? pend_q : irq_s;

  // Fixed priority select: cause 3 > cause 2 > cause 1
  always_comb begin
    hi_cause  = 2'd0;
    hi_onehot = 3'b000;
    if (pend_vec[2]) begin
      hi_cause  = 2'd3;
      hi_onehot = 3'b100;
    end else if (pend_vec[1]) begin
      hi_cause  = 2'd2;
      hi_onehot = 3'b010;
    end else if (pend_vec[0]) begin
      hi_cause  = 2'd1;
      hi_onehot = 3'b001;
    end
  end

  // Next-state, trap issue and mret acceptance
  always_comb begin
    state_n = state_q;
    cause_n = 2'b00;
    inh_n   = inh_q;
    mie_n   = mie_q;
    clr     = 3'b000;
    case (state_q)
      IDLE: begin
        // mie only ever reads 0 in IDLE straight after a RESET_MIE=0 reset
        if (!mie_q && bus.mret) begin
          mie_n = 1'b1;
        end else if (mie_q && (pend_vec != 3'b000) && !bus.hold) begin
          cause_n = hi_cause;
          clr     = hi_onehot;
          mie_n   = 1'b0;
          state_n = TRAP;
        end
      end
      TRAP: begin
        // pulse already issued; hold and mret are not looked at here
        inh_n   = 1'b1;
        state_n = HANDLER;
      end
      HANDLER: begin
        if (bus.mret) begin
          mie_n   = 1'b1;
          inh_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        inh_n   = 1'b0;
      end
    endcase
    // A rising edge on the same cycle as the clear wins, so no edge is lost
    if (EDGE_MODE != 0) pend_n = (pend_q & ~clr) | rise;
    else                pend_n = 3'b000;
  end

  // State, output and pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cause_q  <= 2'b00;
      inh_q    <= 1'b0;
      mie_q    <= RESET_MIE;
      pend_q   <= 3'b000;
      irq_prev <= 3'b000;
    end else begin
      state_q  <= state_n;
      cause_q  <= cause_n;
      inh_q    <= inh_n;
      mie_q    <= mie_n;
      pend_q   <= pend_n;
      irq_prev <= irq_s;
    end
  end

  assign bus.int_cause  = cause_q;
  assign bus.in_handler = inh_q;
  assign bus.pending    = pend_vec;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_my_int_ctrl.sv
// Directed bench for my_int_ctrl: an edge-mode and a level-mode instance
// share clk, rst_n, hold and mret; each has its own irq_in.
module tb_my_int_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  logic       mret = 1'b0;
  logic [2:0] irq_e = 3'b000;
  logic [2:0] irq_l = 3'b000;
  logic       use_lv = 1'b0;

  int errors = 0;
  int checks = 0;
  int pulse_e = 0;
  int pulse_l = 0;

  my_int_ctrl_if ed ();
  my_int_ctrl_if lv ();

  assign ed.irq_in = irq_e;
  assign ed.hold   = hold;
  assign ed.mret   = mret;
  assign lv.irq_in = irq_l;
  assign lv.hold   = hold;
  assign lv.mret   = mret;

  my_int_ctrl #(.EDGE_MODE(1), .RESET_MIE(1'b1)) dut_e (.clk(clk), .rst_n(rst_n), .bus(ed));
  my_int_ctrl #(.EDGE_MODE(0), .RESET_MIE(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(lv));

  // Observed signals of whichever instance is under test
  logic [1:0] cause_m;
  logic       inh_m;
  assign cause_m = use_lv ? lv.int_cause : ed.int_cause;
  assign inh_m   = use_lv ? lv.in_handler : ed.in_handler;

  // clock / reset block
  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && ed.int_cause != 2'b00) pulse_e++;
    if (rst_n && lv.int_cause != 2'b00) pulse_l++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a trap pulse, check its cause and that it lasts one cycle
  task automatic wait_pulse(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    while (cause_m == 2'b00 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_cause"}, {6'd0, cause_m}, {6'd0, exp});
    tick();
    check({tag, "_single"}, {6'd0, cause_m}, 8'h00);
    check({tag, "_inh"}, {7'd0, inh_m}, 8'h01);
  endtask

  task automatic do_mret(input string tag);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check({tag, "_mret_inh"}, {7'd0, inh_m}, 8'h00);
  endtask

  initial begin
    int p0;
    // --- reset and idle ---
    repeat (3) tick();
    check("rst_state", {6'd0, ed.state}, 8'h00);
    check("rst_pend", {5'd0, ed.pending}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {3'd0, ed.int_cause, ed.in_handler, ed.pending}, 8'h00);
    end

    // --- single edge, exact latency ---
    irq_e = 3'b001;
    tick();
    check("lat_pend_k", {5'd0, ed.pending}, 8'h01);
    check("lat_cause_k", {6'd0, ed.int_cause}, 8'h00);
    tick();
    check("lat_cause_k1", {6'd0, ed.int_cause}, 8'h01);
    check("lat_pend_clr", {5'd0, ed.pending}, 8'h00);
    tick();
    check("lat_cause_k2", {6'd0, ed.int_cause}, 8'h00);
    check("lat_inh", {7'd0, ed.in_handler}, 8'h01);
    check("lat_state", {6'd0, ed.state}, 8'h02);
    do_mret("lat");
    repeat (3) tick();
    check("lat_no_retrig", {6'd0, ed.int_cause}, 8'h00);
    irq_e = 3'b000;
    tick();

    // --- three simultaneous edges, priority order ---
    p0 = pulse_e;
    irq_e = 3'b111;
    wait_pulse("pri3", 2'd3);
    check("pri_pend", {5'd0, ed.pending}, 8'h03);
    do_mret("pri3");
    wait_pulse("pri2", 2'd2);
    do_mret("pri2");
    wait_pulse("pri1", 2'd1);
    do_mret("pri1");
    repeat (6) tick();
    check("pri_count", pulse_e - p0, 8'd3);
    irq_e = 3'b000;
    tick();

    // --- edge during handler, hold after mret ---
    irq_e = 3'b001;
    wait_pulse("hold_a", 2'd1);
    irq_e = 3'b011;
    tick();
    check("hold_pend", {5'd0, ed.pending}, 8'h02);
    repeat (2) tick();
    check("hold_no_hdl_pulse", {6'd0, ed.int_cause}, 8'h00);
    mret = 1'b1;
    hold = 1'b1;
    tick();
    mret = 1'b0;
    check("hold_mret", {7'd0, ed.in_handler}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_block", {6'd0, ed.int_cause}, 8'h00);
    end
    hold = 1'b0;
    tick();
    check("hold_release", {6'd0, ed.int_cause}, 8'h02);
    tick();
    check("hold_single", {6'd0, ed.int_cause}, 8'h00);
    tick();
    do_mret("hold");
    irq_e = 3'b000;
    tick();

    // --- mret in IDLE is ignored ---
    p0 = pulse_e;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    repeat (3) tick();
    check("idle_mret_state", {6'd0, ed.state}, 8'h00);
    check("idle_mret_out", {5'd0, ed.int_cause, ed.in_handler}, 8'h00);
    check("idle_mret_pulses", pulse_e - p0, 8'd0);

    // --- async reset in the middle of a handler ---
    irq_e = 3'b100;
    wait_pulse("rst_mid", 2'd3);
    irq_e = 3'b101;
    tick();
    check("rst_mid_pend", {5'd0, ed.pending}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", {5'd0, ed.int_cause, ed.in_handler}, 8'h00);
    check("rst_mid_pend0", {5'd0, ed.pending}, 8'h00);
    check("rst_mid_state", {6'd0, ed.state}, 8'h00);
    irq_e = 3'b000;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // --- level mode: held request re-issued once per mret ---
    use_lv = 1'b1;
    p0 = pulse_l;
    irq_l = 3'b001;
    #1;
    check("lvl_pend", {5'd0, lv.pending}, 8'h01);
    for (int r = 0; r < 3; r++) begin
      wait_pulse("lvl", 2'd1);
      repeat (3) tick();
      check("lvl_in_hdl", {6'd0, lv.state}, 8'h02);
      do_mret("lvl");
    end
    check("lvl_count", pulse_l - p0, 8'd3);
    irq_l = 3'b000;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/my_int_ctrl.md
Name: my_int_ctrl

Overview:
- Interrupt controller producing the 2-bit `int_cause` trap request and consuming the `mret` return signal of the PC/trap unit.
- Latches up to three external interrupt sources and arbitrates them by fixed priority.
- Issues exactly one single-cycle cause pulse per accepted trap.
- Masks further traps until the handler's `mret`, because the PC holds only one saved return address.

Parameters:
- EDGE_MODE, 1, 1 = rising-edge-triggered sources with pending latches; 0 = level-sensitive (pending equals the live input).
- RESET_MIE, 1, value of the global interrupt enable (mie) after reset.

Ports:
- clk  input  1  system clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- irq_in  input  3  interrupt requests; bit i maps to cause i+1
- hold  input  1  1 = pipeline cannot accept a trap this cycle; defers issue
- mret  input  1  single-cycle return-from-handler strobe (same signal fed to the PC)
- int_cause  output  2  registered trap cause; 00 = none; nonzero for exactly one cycle per trap
- in_handler  output  1  1 from trap issue until mret is accepted
- pending  output  3  current pending vector, for debug/LEDs

Behaviour:
- Reset (rst_n=0, async): state=IDLE, int_cause=00, in_handler=0, pending=000, irq_prev=000, mie=RESET_MIE.
- Edge mode:
  - irq_prev <= irq_in every cycle.
  - rise[i] = irq_in[i] & ~irq_prev[i].
  - pending[i] is set by rise[i] and cleared only when cause i+1 is issued.
  - If set and clear coincide, set wins: pending stays 1, no lost edge.
- Level mode: pending = irq_in (combinational); nothing is latched and nothing is cleared.
- Priority: cause 3 (irq_in[2]) > cause 2 > cause 1.
- State machine:
  - IDLE:
    - If mie & (pending!=0) & ~hold: load int_cause with the highest pending cause, clear that pending bit (edge mode), set mie=0, go to TRAP.
    - Otherwise int_cause=00.
  - TRAP:
    - int_cause holds its value for this one cycle only; hold is ignored because the pulse is already issued.
    - Next posedge: int_cause<=00, in_handler<=1, go to HANDLER.
  - HANDLER:
    - New edges still latch into pending; no trap is issued.
    - mret=1: mie<=1, in_handler<=0, go to IDLE.
- mret in IDLE or TRAP is ignored; no state change.
- mie is internal. RESET_MIE=0 means no trap is ever issued until an mret occurs. That mret is accepted in any state: it sets mie and returns to IDLE.
- Latency (edge mode): a rise sampled at posedge k sets pending at k. int_cause is nonzero during cycle k+1..k+2. The PC samples it at posedge k+2.
- Back-to-back: the earliest next trap after mret is sampled at posedge m. It loads int_cause at posedge m+1, so there is one cycle minimum gap.
- Reset mid-handler: returns to IDLE, pending is lost, mie=RESET_MIE.

Optional Feature:
- Macro INT_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer (reset to 0) before edge detection and level use. This adds 2 cycles of latency to every path above.
- Undefined: irq_in is used directly and is assumed synchronous to clk.

Test Plan:
- Reset release, irq_in=000 for 10 cycles -> int_cause=00 and in_handler=0 throughout; pending=000.
- Edge mode, irq_in 000->001 at posedge 5 -> pending=001 at 5; int_cause=01 for one cycle after posedge 6; in_handler=1 from posedge 7; pending=000.
- irq_in 000->111 in one cycle -> int_cause=11 first. After mret, int_cause=10; after the second mret, int_cause=01. Exactly three pulses.
- irq_in[1] rises while in HANDLER, hold=1 held for 3 cycles after mret -> no pulse while hold=1; int_cause=10 issued one cycle after hold drops.
- mret pulsed in IDLE with pending=000 -> no state change, int_cause stays 00. Then rst_n=0 asserted mid-HANDLER -> immediate in_handler=0, int_cause=00.
- Level mode (EDGE_MODE=0), irq_in[0] held high -> int_cause=01 re-issued once after every mret; no pulse while in HANDLER.
